// File: rtl/pkt_pkg.sv
// Shared definitions for the packet classifier: class codes, FSM states,
// broadcast address and the destination classification helper.
package pkt_pkg;

  localparam logic [1:0] CLS_NONE  = 2'd0;
  localparam logic [1:0] CLS_LOCAL = 2'd1;
  localparam logic [1:0] CLS_FWD   = 2'd2;
  localparam logic [1:0] CLS_BCAST = 2'd3;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BODY    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  // Broadcast takes priority so a node never claims all-ones as its own address.
  function automatic logic [1:0] classify(input logic [47:0] dest, input logic [47:0] mac);
    if (dest == BCAST_MAC) return CLS_BCAST;
    else if (dest == mac)  return CLS_LOCAL;
    else                   return CLS_FWD;
  endfunction

endpackage

// File: rtl/pkt_stats_cnt.sv
// Wrapping 32-bit statistics counters for delivered, forwarded and truncated
// packets; fed from the registered output stream of pkt_classify.
module pkt_stats_cnt
  import pkt_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        pkt_end,
  input  logic [1:0]  cls,
  input  logic        trunc,
  output logic [31:0] local_cnt,
  output logic [31:0] fwd_cnt,
  output logic [31:0] trunc_cnt
);

  logic [2:0]       inc;
  logic [2:0][31:0] cnt_reg;

  assign inc[0] = pkt_end && ((cls == CLS_LOCAL) || (cls == CLS_BCAST));
  assign inc[1] = pkt_end && (cls == CLS_FWD);
  assign inc[2] = trunc;

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (i_rst)       cnt_reg[i] <= '0;
      else if (inc[i]) cnt_reg[i] <= cnt_reg[i] + 32'd1;
    end
  end

  assign local_cnt = cnt_reg[0];
  assign fwd_cnt   = cnt_reg[1];
  assign trunc_cnt = cnt_reg[2];

endmodule

// File: rtl/pkt_classify.sv
// Ethernet RX classifier: tags each packet local/forward/broadcast from its
// destination MAC and truncates packets longer than MAX_BEATS.
// Optional statistics counters are built when PKT_CLASSIFY_STATS_EN is defined.
module pkt_classify
  import pkt_pkg::*;
#(
  parameter int MAX_BEATS = 190
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [47:0] i_local_mac,
  input  logic        s_axis_tvalid,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic [7:0]  s_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic [7:0]  m_axis_tkeep,
  output logic [1:0]  m_axis_tuser,
  output logic [31:0] o_local_cnt,
  output logic [31:0] o_fwd_cnt,
  output logic [31:0] o_trunc_cnt
);

  localparam logic [15:0] MAX_B = 16'(MAX_BEATS);

  state_t      state_reg;
  logic [15:0] beat_cnt_reg;
  logic [1:0]  cls_reg;

  logic [15:0] beat_num;
  logic [1:0]  sop_cls;
  logic        trunc_now;

  // beat_num is the 1-based index the current input beat would take in the output packet.
  always_comb begin
    beat_num  = (state_reg == ST_IDLE) ? 16'd1 : beat_cnt_reg + 16'd1;
    sop_cls   = classify(s_axis_tdata[47:0], i_local_mac);
    trunc_now = s_axis_tvalid && !s_axis_tlast && (state_reg != ST_DISCARD)
                && (beat_num == MAX_B);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      beat_cnt_reg  <= '0;
      cls_reg       <= CLS_NONE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= 8'hFF;
      m_axis_tuser  <= CLS_NONE;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= 8'hFF;
      m_axis_tuser  <= CLS_NONE;
      if (s_axis_tvalid) begin
        case (state_reg)
          ST_IDLE, ST_BODY: begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= s_axis_tlast || trunc_now;
            m_axis_tkeep  <= trunc_now ? 8'hFF : s_axis_tkeep;
            m_axis_tuser  <= (state_reg == ST_IDLE) ? sop_cls : cls_reg;
            beat_cnt_reg  <= beat_num;
            if (state_reg == ST_IDLE) cls_reg <= sop_cls;
            if (s_axis_tlast)   state_reg <= ST_IDLE;
            else if (trunc_now) state_reg <= ST_DISCARD;
            else                state_reg <= ST_BODY;
          end
          ST_DISCARD: begin
            if (s_axis_tlast) state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef PKT_CLASSIFY_STATS_EN
  // Marks the output beat that closed a truncated packet.
  logic trunc_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) trunc_reg <= 1'b0;
    else       trunc_reg <= trunc_now;
  end

  pkt_stats_cnt u_stats (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .pkt_end   (m_axis_tvalid && m_axis_tlast),
    .cls       (m_axis_tuser),
    .trunc     (trunc_reg),
    .local_cnt (o_local_cnt),
    .fwd_cnt   (o_fwd_cnt),
    .trunc_cnt (o_trunc_cnt)
  );
`else
  assign o_local_cnt = '0;
  assign o_fwd_cnt   = '0;
  assign o_trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_classify.sv
// Scoreboard bench for pkt_classify: expected beats are queued as stimulus is
// driven and checked (content and 1-cycle latency) as the DUT emits them.
module tb_pkt_classify;
  import pkt_pkg::*;

  localparam int MAX_BEATS = 190;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] local_mac;
  logic        s_valid;
  logic [63:0] s_data;
  logic        s_last;
  logic [7:0]  s_keep;
  logic        m_valid;
  logic [63:0] m_data;
  logic        m_last;
  logic [7:0]  m_keep;
  logic [1:0]  m_user;
  logic [31:0] local_cnt, fwd_cnt, trunc_cnt;

  pkt_classify #(.MAX_BEATS(MAX_BEATS)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_local_mac   (local_mac),
    .s_axis_tvalid (s_valid),
    .s_axis_tdata  (s_data),
    .s_axis_tlast  (s_last),
    .s_axis_tkeep  (s_keep),
    .m_axis_tvalid (m_valid),
    .m_axis_tdata  (m_data),
    .m_axis_tlast  (m_last),
    .m_axis_tkeep  (m_keep),
    .m_axis_tuser  (m_user),
    .o_local_cnt   (local_cnt),
    .o_fwd_cnt     (fwd_cnt),
    .o_trunc_cnt   (trunc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [7:0]  keep;
    logic [1:0]  user;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef PKT_CLASSIFY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // reference model state
  bit       m_in_pkt, m_discard;
  int       m_n;
  logic [1:0] m_cls;
  int       e_local, e_fwd, e_trunc;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("latency", cyc, e.due);
        chk("tdata", m_data, e.data);
        chk("tlast", m_last, e.last);
        chk("tkeep", m_keep, e.keep);
        chk("tuser", m_user, e.user);
        $display("beat out cyc=%0d user=%0d last=%0d keep=%h", cyc, m_user, m_last, m_keep);
      end
    end else if (!rst) begin
      chk("idle_tlast", m_last, 0);
      chk("idle_tkeep", m_keep, 8'hFF);
      chk("idle_tuser", m_user, 0);
    end
  end

  function automatic void model_reset();
    m_in_pkt = 0; m_discard = 0; m_n = 0; m_cls = CLS_NONE;
    e_local = 0; e_fwd = 0; e_trunc = 0;
  endfunction

  task automatic idle_cycle();
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l, input logic [7:0] k);
    exp_t e;
    s_valid = 1'b1; s_data = d; s_last = l; s_keep = k;
    if (m_discard) begin
      if (l) m_discard = 0;
    end else begin
      if (!m_in_pkt) begin
        m_n = 1;
        if (d[47:0] == 48'hFFFF_FFFF_FFFF) m_cls = 2'd3;
        else if (d[47:0] == local_mac)     m_cls = 2'd1;
        else                               m_cls = 2'd2;
      end else begin
        m_n++;
      end
      e.data = d; e.user = m_cls; e.due = cyc + 1;
      if (!l && m_n == MAX_BEATS) begin
        e.last = 1; e.keep = 8'hFF; m_discard = 1; m_in_pkt = 0; e_trunc++;
      end else begin
        e.last = l; e.keep = k; m_in_pkt = !l;
      end
      if (e.last) begin
        if (m_cls == 2'd2) e_fwd++; else e_local++;
      end
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input logic [47:0] dest, input int nbeats,
                          input logic [7:0] last_keep, input int gap);
    for (int i = 0; i < nbeats; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      if (i == 0) d[47:0] = dest;
      send_beat(d, i == nbeats - 1, (i == nbeats - 1) ? last_keep : 8'hFF);
      if (i != nbeats - 1) repeat (gap) idle_cycle();
    end
  endtask

  task automatic chk_counters(input string tag);
    repeat (2) idle_cycle();
    chk({tag, "_local_cnt"}, local_cnt, STATS ? 32'(e_local) : 32'd0);
    chk({tag, "_fwd_cnt"},   fwd_cnt,   STATS ? 32'(e_fwd)   : 32'd0);
    chk({tag, "_trunc_cnt"}, trunc_cnt, STATS ? 32'(e_trunc) : 32'd0);
    chk({tag, "_drained"}, exp_q.size(), 0);
    $display("packet %s done: local=%0d fwd=%0d trunc=%0d", tag, local_cnt, fwd_cnt, trunc_cnt);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tvalid"}, m_valid, 0);
    chk({tag, "_tdata"},  m_data, 0);
    chk({tag, "_tlast"},  m_last, 0);
    chk({tag, "_tkeep"},  m_keep, 8'hFF);
    chk({tag, "_tuser"},  m_user, 0);
    chk({tag, "_cnts"},   {local_cnt, fwd_cnt} | 64'(trunc_cnt), 0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 0; s_data = '0; s_last = 0; s_keep = 8'hFF;
    local_mac = 48'h0A0B0C0D0E0F;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;
    idle_cycle();

    // local packet; MAC change mid-packet must not alter its class
    for (int i = 0; i < 8; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      if (i == 0) d[47:0] = 48'h0A0B0C0D0E0F;
      if (i == 3) local_mac = 48'h0000_0000_0BAD;
      send_beat(d, i == 7, (i == 7) ? 8'h0F : 8'hFF);
    end
    local_mac = 48'h0A0B0C0D0E0F;
    chk_counters("local8");

    send_pkt(48'h112233445566, 3, 8'hFF, 2);
    chk_counters("fwd_gap");

    // broadcast single beat, immediately followed by a new SOP
    send_pkt(48'hFFFF_FFFF_FFFF, 1, 8'h01, 0);
    send_pkt(48'h0A0B0C0D0E0F, 2, 8'h3F, 0);
    chk_counters("bcast1");

    send_pkt(48'h112233445566, 200, 8'hFF, 0);
    send_pkt(48'h0A0B0C0D0E0F, 4, 8'h07, 0);
    chk_counters("trunc200");

    send_pkt(48'h665544332211, MAX_BEATS, 8'h1F, 0);
    chk_counters("exact190");

    // reset on beat 5 of 10; beats 6..10 form a new packet
    for (int i = 0; i < 4; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      if (i == 0) d[47:0] = 48'h112233445566;
      send_beat(d, 1'b0, 8'hFF);
    end
    rst = 1'b1; s_valid = 1'b1; s_data = {$urandom, $urandom}; s_last = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk_reset_state("midrst");
    rst = 1'b0;
    send_pkt(48'h0A0B0C0D0E0F, 5, 8'h03, 0);
    chk_counters("after_rst");

    repeat (3) idle_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
